// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/DMA memory bus arbiter: state and owner encodings,
// bus widths and the wait-state helper.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMER_W = 3;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_CPU_ACC,
        ARB_CPU_WAIT,
        ARB_DMA_ACC,
        ARB_DMA_WAIT,
        ARB_DMA_END
    } arb_state_e;

    // OWN_NONE after reset lets the CPU win the very first contested decision.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

    function automatic logic [TIMER_W-1:0] extra_waits(input logic io, input int unsigned io_wait);
        return io ? TIMER_W'(io_wait) : '0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of CPU, DMA and memory-side bus signals around the arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int BURST_W = 4
);

    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_io;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_hold;

    logic               dma_req;
    logic               dma_we;
    logic [ADDR_W-1:0]  dma_addr;
    logic [BURST_W-1:0] dma_len;
    logic [DATA_W-1:0]  dma_wdata;
    logic               dma_gnt;
    logic               dma_ack;
    logic [DATA_W-1:0]  dma_rdata;
    logic               dma_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              mem_re;
    logic              mem_io;

    modport slave (
        input  cpu_req, cpu_we, cpu_io, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_hold,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_gnt, dma_ack, dma_rdata, dma_done,
        output mem_addr, mem_wdata, mem_we, mem_re, mem_io,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_io, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_hold,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_gnt, dma_ack, dma_rdata, dma_done,
        input  mem_addr, mem_wdata, mem_we, mem_re, mem_io,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_beat_timer.sv
// Loadable down-counter used both as the strobe-length timer and as the
// DMA beat counter; zero flags the final strobe cycle / final beat.
module arb_beat_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared 8-bit memory/I-O bus between the CPU and a DMA port,
// sequencing strobes with I/O wait states and running non-preemptive bursts.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int IO_WAIT = 2,
    parameter int BURST_W = 4
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.slave  bus
);

    arb_state_e state;
    owner_e     last_owner;

    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_we_r;
    logic              mem_re_r;
    logic              mem_io_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic              cpu_ready_r;
    logic              dma_gnt_r;
    logic              dma_ack_r;
    logic              dma_done_r;
    logic [DATA_W-1:0] dma_rdata_r;
    logic              dma_we_r;
    logic [ADDR_W-1:0] dma_addr_r;

    logic               stb_load;
    logic [TIMER_W-1:0] stb_val;
    logic               stb_dec;
    logic               stb_zero;
    logic               beat_load;
    logic               beat_dec;
    logic               beat_zero;

    logic cpu_pend;
    logic dma_pend;
    logic grant_cpu;
    logic grant_dma;
    logic cpu_owns;

    // A request whose completion pulse is showing this cycle is already served.
    assign cpu_pend  = bus.cpu_req && !cpu_ready_r;
    assign dma_pend  = bus.dma_req && !dma_done_r;
    assign grant_cpu = cpu_pend && (!dma_pend || (last_owner != OWN_CPU));
    assign grant_dma = dma_pend && !grant_cpu;
    assign cpu_owns  = (state == ARB_CPU_ACC) || (state == ARB_CPU_WAIT);

    always_comb begin
        stb_load  = 1'b0;
        stb_val   = extra_waits(bus.cpu_io, IO_WAIT);
        stb_dec   = 1'b0;
        beat_load = 1'b0;
        beat_dec  = 1'b0;
        case (state)
            ARB_IDLE: begin
                stb_load  = grant_cpu;
                beat_load = grant_dma;
            end
            ARB_CPU_ACC, ARB_CPU_WAIT: stb_dec  = !stb_zero;
            ARB_DMA_ACC:               beat_dec = 1'b1;
            default: ;
        endcase
    end

    arb_beat_timer #(.W(TIMER_W)) u_stb_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (stb_load),
        .load_val (stb_val),
        .dec      (stb_dec),
        .zero     (stb_zero)
    );

    // Loaded with len-1 so that len 0 naturally yields 2**BURST_W beats.
    arb_beat_timer #(.W(BURST_W)) u_beat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (beat_load),
        .load_val (bus.dma_len - BURST_W'(1)),
        .dec      (beat_dec),
        .zero     (beat_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB_IDLE;
            last_owner  <= OWN_NONE;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_io_r    <= 1'b0;
            cpu_rdata_r <= '0;
            cpu_ready_r <= 1'b0;
            dma_gnt_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
            dma_done_r  <= 1'b0;
            dma_rdata_r <= '0;
            dma_we_r    <= 1'b0;
            dma_addr_r  <= '0;
        end else begin
            cpu_ready_r <= 1'b0;
            dma_ack_r   <= 1'b0;
            dma_done_r  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_cpu) begin
                        state       <= ARB_CPU_ACC;
                        last_owner  <= OWN_CPU;
                        mem_addr_r  <= bus.cpu_addr;
                        mem_wdata_r <= bus.cpu_wdata;
                        mem_io_r    <= bus.cpu_io;
                        mem_we_r    <= bus.cpu_we;
                        mem_re_r    <= !bus.cpu_we;
                    end else if (grant_dma) begin
                        state       <= ARB_DMA_ACC;
                        last_owner  <= OWN_DMA;
                        dma_gnt_r   <= 1'b1;
                        dma_we_r    <= bus.dma_we;
                        dma_addr_r  <= bus.dma_addr;
                        mem_addr_r  <= bus.dma_addr;
                        mem_wdata_r <= bus.dma_wdata;
                        mem_io_r    <= 1'b0;
                        mem_we_r    <= bus.dma_we;
                        mem_re_r    <= !bus.dma_we;
                    end
                end
                ARB_CPU_ACC, ARB_CPU_WAIT: begin
                    if (stb_zero) begin
                        if (mem_re_r) begin
                            cpu_rdata_r <= bus.mem_rdata;
                        end
                        mem_we_r    <= 1'b0;
                        mem_re_r    <= 1'b0;
                        cpu_ready_r <= 1'b1;
                        state       <= ARB_IDLE;
                    end else begin
                        state <= ARB_CPU_WAIT;
                    end
                end
                ARB_DMA_ACC: begin
                    if (mem_re_r) begin
                        dma_rdata_r <= bus.mem_rdata;
                    end
                    mem_we_r   <= 1'b0;
                    mem_re_r   <= 1'b0;
                    dma_ack_r  <= 1'b1;
                    dma_addr_r <= dma_addr_r + ADDR_W'(1);
                    state      <= (beat_zero || !bus.dma_req) ? ARB_DMA_END : ARB_DMA_WAIT;
                end
                // Gap cycle: the source sees dma_ack and presents the next write data.
                ARB_DMA_WAIT: begin
                    mem_addr_r  <= dma_addr_r;
                    mem_wdata_r <= bus.dma_wdata;
                    mem_we_r    <= dma_we_r;
                    mem_re_r    <= !dma_we_r;
                    state       <= ARB_DMA_ACC;
                end
                ARB_DMA_END: begin
                    dma_gnt_r  <= 1'b0;
                    dma_done_r <= 1'b1;
                    state      <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Gated by reset so the stall also drops immediately during reset.
    assign bus.cpu_hold  = reset && !cpu_owns && (dma_gnt_r || cpu_pend);

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_re    = mem_re_r;
    assign bus.mem_io    = mem_io_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.cpu_ready = cpu_ready_r;
    assign bus.dma_gnt   = dma_gnt_r;
    assign bus.dma_ack   = dma_ack_r;
    assign bus.dma_rdata = dma_rdata_r;
    assign bus.dma_done  = dma_done_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset abort, CPU memory/I-O access,
// DMA bursts with wrap and early stop, and CPU/DMA alternation.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.BURST_W(4)) bus ();

    mem_bus_arbiter #(.IO_WAIT(2), .BURST_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Simple RAM model: cleared while reset is low, 0x10 preloaded with 0xA5.
    logic [7:0] mem [256];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'hA5 : 8'h00;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    int errors = 0;
    int checks = 0;
    int we_cnt, ready_at, io_bad, ack_cnt, done_cnt, hold_bad;
    int last_ack_k, done_k, n;
    logic [7:0] rd0, rd1;
    int seq [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_io    = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 8'h00;
        bus.dma_len   = 4'd0;
        bus.dma_wdata = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_cpu_ready", bus.cpu_ready, 0);
        check("rst_cpu_hold",  bus.cpu_hold,  0);
        check("rst_dma_gnt",   bus.dma_gnt,   0);
        check("rst_mem_we",    bus.mem_we,    0);
        check("rst_mem_re",    bus.mem_re,    0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        reset = 1'b1;

        // Reset asserted in the middle of a DMA read beat
        @(negedge clk);
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h20; bus.dma_len = 4'd4;
        @(negedge clk);
        check("t1_beat_in_flight", bus.mem_re, 1);
        check("t1_beat_addr", bus.mem_addr, 8'h20);
        #2 reset = 1'b0;
        #1;
        check("t1_async_re",   bus.mem_re,   0);
        check("t1_async_gnt",  bus.dma_gnt,  0);
        check("t1_async_addr", bus.mem_addr, 0);
        check("t1_async_hold", bus.cpu_hold, 0);
        bus.dma_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t1_idle_gnt",  bus.dma_gnt,  0);
        check("t1_idle_re",   bus.mem_re,   0);
        check("t1_idle_hold", bus.cpu_hold, 0);

        // CPU memory read of 0x10
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_io = 1'b0; bus.cpu_addr = 8'h10;
        #1;
        check("t2_hold_pending", bus.cpu_hold, 1);
        @(negedge clk);
        check("t2_re",       bus.mem_re,    1);
        check("t2_addr",     bus.mem_addr,  8'h10);
        check("t2_io",       bus.mem_io,    0);
        check("t2_hold_own", bus.cpu_hold,  0);
        check("t2_early",    bus.cpu_ready, 0);
        @(negedge clk);
        check("t2_ready", bus.cpu_ready, 1);
        check("t2_rdata", bus.cpu_rdata, 8'hA5);
        check("t2_re_off", bus.mem_re,   0);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("t2_ready_pulse", bus.cpu_ready, 0);
        check("t2_addr_hold",   bus.mem_addr,  8'h10);
        check("t2_no_regrant",  bus.mem_re,    0);

        // CPU I/O write with two wait states
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_io = 1'b1;
        bus.cpu_addr = 8'h80; bus.cpu_wdata = 8'h3C;
        we_cnt = 0; ready_at = 0; io_bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_cnt++;
                if (!bus.mem_io) io_bad++;
            end
            if (bus.cpu_ready && ready_at == 0) begin
                ready_at = k;
                bus.cpu_req = 1'b0;
            end
        end
        check("t3_we_cycles", we_cnt,   3);
        check("t3_ready_at",  ready_at, 4);
        check("t3_io_sel",    io_bad,   0);
        check("t3_written",   mem[8'h80], 8'h3C);

        // DMA write burst of 3 beats wrapping 0xFF -> 0x00
        @(negedge clk);
        bus.cpu_io = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'hFE;
        bus.dma_len = 4'd3; bus.dma_wdata = 8'h11;
        ack_cnt = 0; done_cnt = 0; hold_bad = 0; io_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dma_gnt && !bus.cpu_hold) hold_bad++;
            if (bus.dma_gnt && bus.mem_io) io_bad++;
            if (bus.dma_ack) begin
                ack_cnt++;
                bus.dma_wdata = (ack_cnt == 1) ? 8'h22 : 8'h33;
            end
            if (bus.dma_done) begin
                done_cnt++;
                bus.dma_req = 1'b0;
            end
        end
        check("t4_acks",     ack_cnt,  3);
        check("t4_done",     done_cnt, 1);
        check("t4_hold",     hold_bad, 0);
        check("t4_mem_only", io_bad,   0);
        check("t4_mem_fe",   mem[8'hFE], 8'h11);
        check("t4_mem_ff",   mem[8'hFF], 8'h22);
        check("t4_mem_00",   mem[8'h00], 8'h33);
        check("t4_mem_01",   mem[8'h01], 8'h00);

        // DMA read of len 0 (16 beats) stopped during beat 2
        @(negedge clk);
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'hFF; bus.dma_len = 4'd0;
        ack_cnt = 0; done_cnt = 0; last_ack_k = -1; done_k = -1; rd0 = 8'h00; rd1 = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.dma_ack) begin
                if (ack_cnt == 0) rd0 = bus.dma_rdata;
                else              rd1 = bus.dma_rdata;
                ack_cnt++;
                last_ack_k = k;
            end
            if (bus.mem_re && ack_cnt == 1) bus.dma_req = 1'b0;
            if (bus.dma_done) begin
                done_cnt++;
                done_k = k;
            end
        end
        check("t6_acks",      ack_cnt,  2);
        check("t6_done",      done_cnt, 1);
        check("t6_done_next", done_k,   last_ack_k + 1);
        check("t6_rdata0",    rd0,      8'h22);
        check("t6_rdata1",    rd1,      8'h33);

        // CPU and DMA both requesting continuously from reset
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_io = 1'b0; bus.cpu_addr = 8'h10;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40; bus.dma_len = 4'd1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 200 && n < 10; k++) begin
            @(negedge clk);
            if (bus.cpu_ready && n < 10) begin
                seq[n] = 0;
                n++;
            end
            if (bus.dma_done && n < 10) begin
                seq[n] = 1;
                n++;
            end
        end
        check("t5_grant_count", n, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t5_grant%0d", i), seq[i], i % 2);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
